// File: rtl/dac_seq_pkg.sv
// Shared types and default sizing for the DAC sample sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dac_seq_pkg;

    // Playback states of the sequencer FSM
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam int DEF_DW    = 16;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_DIVW  = 8;

    // Width of an occupancy counter able to hold 0..depth inclusive
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dac_seq_if.sv
// Write channel from the SPI word loader into the sample FIFO.
// Latency: wires only.
// Backpressure: a word transfers when i_wr_valid and o_wr_ready are both high.
interface dac_seq_if #(
    parameter int DW = 16
);
    logic          i_wr_valid;
    logic [DW-1:0] i_wr_data;
    logic          o_wr_ready;

    // SPI loader side: offers words, observes ready
    modport master (
        output i_wr_valid,
        output i_wr_data,
        input  o_wr_ready
    );

    // Sequencer side: accepts words, drives ready
    modport slave (
        input  i_wr_valid,
        input  i_wr_data,
        output o_wr_ready
    );

endinterface

// File: rtl/dac_seq_fifo.sv
// Synchronous sample FIFO with registered count/pointers and head-to-tail recirculation.
// Latency: a pushed word is visible at the head and in count the cycle after the push.
// Backpressure: pushes while full are dropped (even with a same-cycle pop); pops while empty are ignored.
module dac_seq_fifo
    import dac_seq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int DW    = DEF_DW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_vld,
    input  logic [DW-1:0]            push_dat,
    input  logic                     pop_vld,
    input  logic                     recirc_vld,
    output logic [DW-1:0]            head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop, do_recirc;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == LW'(DEPTH));
    assign head_dat = mem_q[rd_ptr_q];
    assign count    = cnt_q;

    // Next-state for storage, pointers and count; recirculation moves head to tail with count unchanged
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        do_recirc = recirc_vld && !empty;
        do_push   = push_vld && !full && !do_recirc;
        do_pop    = pop_vld && !empty && !do_recirc;

        if (do_recirc) begin
            // When full the tail slot is the head slot, so this rewrites the word in place
            mem_d[wr_ptr_q] = mem_q[rd_ptr_q];
            wr_ptr_d        = wr_ptr_q + AW'(1);
            rd_ptr_d        = rd_ptr_q + AW'(1);
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + LW'(1);
                2'b01:   cnt_d = cnt_q - LW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Sample storage carries no reset; count and pointers define validity
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/dac_seq.sv
// Paced sample sequencer: buffers SPI words and presents one to the DAC every i_div+1 clocks. Optional DAC_SEQ_LOOP_EN adds i_loop replay.
// Latency: first o_tick i_div+1 cycles after i_start is sampled; new o_data one cycle after its tick.
// Backpressure: o_wr_ready low when the FIFO is full (or looping while busy); a tick on an empty FIFO sets o_underrun and stalls.
module dac_seq
    import dac_seq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int DW    = DEF_DW,
    parameter int DIVW  = DEF_DIVW
) (
    input  logic                   i_clk,
    input  logic                   i_resetn,
    dac_seq_if.slave               wr,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic [DIVW-1:0]        i_div,
    input  logic                   i_clr_err,
`ifdef DAC_SEQ_LOOP_EN
    input  logic                   i_loop,
`endif
    output logic [DW-1:0]          o_data,
    output logic                   o_tick,
    output logic                   o_busy,
    output logic                   o_underrun,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int LW = $clog2(DEPTH) + 1;

    state_t          state_q, state_d;
    logic [DIVW-1:0] cnt_q, cnt_d;
    logic [DW-1:0]   data_q, data_d;
    logic            tick_q, tick_d;
    logic            busy_q, busy_d;
    logic            underrun_q, underrun_d;

    logic            loop_on;
    logic            pop_vld, recirc_vld;
    logic            fifo_empty, fifo_full;
    logic [DW-1:0]   fifo_head;
    logic [LW-1:0]   fifo_count;

`ifdef DAC_SEQ_LOOP_EN
    assign loop_on = i_loop;
`else
    assign loop_on = 1'b0;
`endif

    // Writes are refused while looping playback owns the tail of the buffer
    assign wr.o_wr_ready = !fifo_full && !(loop_on && busy_q);

    dac_seq_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk        (i_clk),
        .rst_n      (i_resetn),
        .push_vld   (wr.i_wr_valid && wr.o_wr_ready),
        .push_dat   (wr.i_wr_data),
        .pop_vld    (pop_vld),
        .recirc_vld (recirc_vld),
        .head_dat   (fifo_head),
        .count      (fifo_count),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    // FSM next-state, rate divider, sample capture and underrun flag
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        underrun_d = underrun_q;
        pop_vld    = 1'b0;
        recirc_vld = 1'b0;

        // Clear first so a same-cycle underrun below takes priority
        if (i_clr_err) begin
            underrun_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    state_d = ST_RUN;
                    cnt_d   = i_div;
                end
            end
            ST_RUN: begin
                if (i_stop) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    // Sample slot: this is the cycle o_tick is high
                    cnt_d = i_div;
                    if (!fifo_empty) begin
                        data_d = fifo_head;
                        if (loop_on) begin
                            recirc_vld = 1'b1;
                        end else begin
                            pop_vld = 1'b1;
                        end
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = ST_STALL;
                    end
                end else begin
                    cnt_d = cnt_q - DIVW'(1);
                end
            end
            ST_STALL: begin
                if (i_stop) begin
                    state_d = ST_IDLE;
                end else if (!fifo_empty) begin
                    state_d = ST_RUN;
                    cnt_d   = i_div;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // o_tick is registered, so it is precomputed from the counter value entering the next cycle
        tick_d = (state_d == ST_RUN) && (cnt_d == '0);
        busy_d = (state_d != ST_IDLE);
    end

    // State, divider and output registers
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            tick_q     <= tick_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
        end
    end

    assign o_data     = data_q;
    assign o_tick     = tick_q;
    assign o_busy     = busy_q;
    assign o_underrun = underrun_q;
    assign o_level    = fifo_count;

endmodule

// File: tb/tb_dac_seq.sv
// Directed bench for dac_seq: playback timing, underrun/stall, backpressure, start/stop, async reset, loop replay.
// Latency: n/a.
// Backpressure: n/a.
module tb_dac_seq;
    import dac_seq_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int DIVW  = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic            i_clk     = 1'b0;
    logic            i_resetn  = 1'b0;
    logic            i_start   = 1'b0;
    logic            i_stop    = 1'b0;
    logic            i_clr_err = 1'b0;
    logic [DIVW-1:0] i_div     = '0;
`ifdef DAC_SEQ_LOOP_EN
    logic            i_loop    = 1'b0;
`endif
    logic [DW-1:0]   o_data;
    logic            o_tick;
    logic            o_busy;
    logic            o_underrun;
    logic [LW-1:0]   o_level;

    int vectors = 0;
    int errs    = 0;

    dac_seq_if #(.DW(DW)) wr_if ();

    dac_seq #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .DIVW  (DIVW)
    ) dut (
        .i_clk      (i_clk),
        .i_resetn   (i_resetn),
        .wr         (wr_if),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .i_div      (i_div),
        .i_clr_err  (i_clr_err),
`ifdef DAC_SEQ_LOOP_EN
        .i_loop     (i_loop),
`endif
        .o_data     (o_data),
        .o_tick     (o_tick),
        .o_busy     (o_busy),
        .o_underrun (o_underrun),
        .o_level    (o_level)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        wr_if.i_wr_valid = 1'b1;
        wr_if.i_wr_data  = w;
        step();
        wr_if.i_wr_valid = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] exp_dat;
        wr_if.i_wr_valid = 1'b0;
        wr_if.i_wr_data  = '0;

        // Reset values
        #12;
        chk("rst_data", 32'(o_data), 32'h0);
        chk("rst_tick", 32'(o_tick), 32'h0);
        chk("rst_busy", 32'(o_busy), 32'h0);
        chk("rst_underrun", 32'(o_underrun), 32'h0);
        chk("rst_level", 32'(o_level), 32'h0);
        chk("rst_ready", 32'(wr_if.o_wr_ready), 32'h1);
        step();
        i_resetn = 1'b1;

        // Basic playback: three words, i_div=3, start in cycle 0
        i_div = 8'd3;
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        chk("load_level", 32'(o_level), 32'd3);
        i_start = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            step();
            if (c == 1) i_start = 1'b0;
            exp_dat = (c >= 13) ? 16'h3333 : (c >= 9) ? 16'h2222 : (c >= 5) ? 16'h1111 : 16'h0000;
            chk($sformatf("play_tick_c%0d", c), 32'(o_tick), 32'(c == 4 || c == 8 || c == 12 || c == 16));
            chk($sformatf("play_data_c%0d", c), 32'(o_data), 32'(exp_dat));
            chk($sformatf("play_unr_c%0d", c), 32'(o_underrun), 32'(c >= 17));
        end
        chk("stall_busy", 32'(o_busy), 32'h1);
        chk("stall_level", 32'(o_level), 32'h0);

        // STALL recovery with i_div=1
        i_div = 8'd1;
        push(16'hABCD);
        chk("rec_tick_a", 32'(o_tick), 32'h0);
        chk("rec_level", 32'(o_level), 32'h1);
        chk("rec_data_hold", 32'(o_data), 32'h3333);
        step();
        chk("rec_tick_b", 32'(o_tick), 32'h0);
        step();
        chk("rec_tick_c", 32'(o_tick), 32'h1);
        step();
        chk("rec_data", 32'(o_data), 32'hABCD);
        chk("rec_level0", 32'(o_level), 32'h0);
        chk("rec_unr_sticky", 32'(o_underrun), 32'h1);

        // Stop plus clear error
        i_stop    = 1'b1;
        i_clr_err = 1'b1;
        step();
        i_stop    = 1'b0;
        i_clr_err = 1'b0;
        chk("stop_busy", 32'(o_busy), 32'h0);
        chk("clr_unr", 32'(o_underrun), 32'h0);
        chk("stop_data_hold", 32'(o_data), 32'hABCD);
        chk("stop_tick", 32'(o_tick), 32'h0);

        // Start and stop together in IDLE: stop wins
        i_start = 1'b1;
        i_stop  = 1'b1;
        step();
        i_start = 1'b0;
        i_stop  = 1'b0;
        chk("startstop_busy", 32'(o_busy), 32'h0);

        // Stop during RUN keeps FIFO; restart continues with next word
        push(16'h0101);
        push(16'h0202);
        push(16'h0303);
        chk("ss_level3", 32'(o_level), 32'd3);
        i_div   = 8'd1;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
        chk("ss_tick1", 32'(o_tick), 32'h1);
        step();
        chk("ss_data1", 32'(o_data), 32'h0101);
        chk("ss_level2", 32'(o_level), 32'd2);
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
        chk("ss_idle", 32'(o_busy), 32'h0);
        chk("ss_kept", 32'(o_level), 32'd2);
        chk("ss_hold", 32'(o_data), 32'h0101);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("ss_rerun", 32'(o_busy), 32'h1);
        step();
        chk("ss_tick2", 32'(o_tick), 32'h1);
        step();
        chk("ss_data2", 32'(o_data), 32'h0202);
        chk("ss_level1", 32'(o_level), 32'd1);
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;

        // Asynchronous reset mid-period
        i_div   = 8'd5;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
        chk("pre_rst_busy", 32'(o_busy), 32'h1);
        #2;
        i_resetn = 1'b0;
        #1;
        chk("arst_busy", 32'(o_busy), 32'h0);
        chk("arst_level", 32'(o_level), 32'h0);
        chk("arst_ready", 32'(wr_if.o_wr_ready), 32'h1);
        chk("arst_data", 32'(o_data), 32'h0);
        chk("arst_tick", 32'(o_tick), 32'h0);
        chk("arst_unr", 32'(o_underrun), 32'h0);
        @(posedge i_clk);
        #1;
        i_resetn = 1'b1;

        // Backpressure: nine pushes, ninth dropped
        for (int i = 0; i < 9; i++) begin
            push(16'(16'h1000 + i));
        end
        chk("bp_level", 32'(o_level), 32'd8);
        chk("bp_ready", 32'(wr_if.o_wr_ready), 32'h0);
        i_div   = 8'd0;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("bp_data%0d", k), 32'(o_data), 32'(16'h1000 + k));
            step();
        end
        chk("bp_unr", 32'(o_underrun), 32'h1);
        chk("bp_last", 32'(o_data), 32'h1007);
        chk("bp_empty", 32'(o_level), 32'h0);
        chk("bp_ready_again", 32'(wr_if.o_wr_ready), 32'h1);
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;

`ifdef DAC_SEQ_LOOP_EN
        // Loop replay: A, B repeating with level held at 2
        i_clr_err = 1'b1;
        step();
        i_clr_err = 1'b0;
        push(16'h000A);
        push(16'h000B);
        i_loop  = 1'b1;
        i_div   = 8'd0;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("loop_ready", 32'(wr_if.o_wr_ready), 32'h0);
        step();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("loop_data%0d", k), 32'(o_data), ((k % 2) == 0) ? 32'h000A : 32'h000B);
            chk($sformatf("loop_level%0d", k), 32'(o_level), 32'd2);
            step();
        end
        chk("loop_no_unr", 32'(o_underrun), 32'h0);
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
        i_loop = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/dac_seq.md
# dac_seq

Sample sequencer that sits between the SPI word loader and the delta-sigma DAC. It buffers 16-bit words arriving from the SPI chain in a small FIFO and presents them to the modulator's data input at a programmable sample rate. This turns single-shot DAC writes into paced waveform playback, with underrun detection and an optional recirculating loop mode.

## Interface
- `DEPTH`, 8: FIFO depth in words; must be a power of 2 and at least 2.
- `DW`, 16: sample width; matches the DAC data input.
- `DIVW`, 8: width of the rate divider.
- `i_clk`  in  1: system clock; the only clock.
- `i_resetn`  in  1: reset, asynchronous and active-low.
- `i_wr_valid`  in  1: write request, driven by the SPI chain's word-detect pulse.
- `i_wr_data`  in  DW: word to enqueue.
- `o_wr_ready`  out  1: FIFO accepts a write this cycle.
- `i_start`  in  1: start playback (single-cycle pulse).
- `i_stop`  in  1: stop playback (single-cycle pulse).
- `i_div`  in  DIVW: sample period is `i_div`+1 clocks.
- `i_clr_err`  in  1: clears `o_underrun`.
- `o_data`  out  DW: current sample, driven to the DAC input.
- `o_tick`  out  1: one-cycle pulse when a sample slot occurs.
- `o_busy`  out  1: state is not IDLE.
- `o_underrun`  out  1: sticky flag; a tick found the FIFO empty.
- `o_level`  out  $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- The FIFO has registered count and pointers; pointers wrap modulo `DEPTH`.
- Push condition: `i_wr_valid` && `o_wr_ready`. `o_wr_ready` = (count < `DEPTH`).
  - A push while full is dropped, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave the count unchanged.
  - There is no bypass: a word pushed in the cycle of a tick is not visible to that tick.
- States:
  - IDLE → RUN on `i_start`. The divider counter loads `i_div`.
  - RUN: the counter decrements every cycle. At 0, assert `o_tick` and reload `i_div`.
    - Tick with FIFO non-empty: pop the head into `o_data`.
    - Tick with FIFO empty: `o_data` holds, `o_underrun` sets, go to STALL.
  - STALL → RUN when count > 0. The counter loads `i_div`; no tick occurs on the transition cycle.
  - RUN or STALL → IDLE on `i_stop`. `o_data` holds and the FIFO contents are kept.
- `i_start` and `i_stop` in the same cycle: stop wins.
- `i_start` while not in IDLE is ignored.
- `i_div` is sampled only at load/reload; a change mid-period takes effect on the next period.
- `o_underrun` clears on `i_clr_err`. If a set condition and `i_clr_err` occur in the same cycle, set wins.
- Reset values:
  - state IDLE, FIFO empty, counter 0.
  - `o_data`=0, `o_tick`=0, `o_busy`=0, `o_underrun`=0, `o_level`=0, `o_wr_ready`=1.
- Reset mid-playback aborts immediately and discards the FIFO.

## Timing
- All outputs are registered except `o_wr_ready`, which is decoded from the registered count.
- If `i_start` is sampled in cycle t, the first `o_tick` fires in cycle t+`i_div`+1. The new `o_data` is visible from cycle t+`i_div`+2.
- Tick period is exactly `i_div`+1 cycles while in RUN. `i_div`=0 gives a tick every cycle.
- `o_level` updates the cycle after a push or pop.

## Configuration
- Macro: `DAC_SEQ_LOOP_EN`.
- Defined:
  - Adds input port `i_loop` (1 bit).
  - While `i_loop`=1 in RUN, each tick pops the head and re-pushes the same word at the tail in the same cycle, so the buffer replays cyclically with count unchanged.
  - `o_wr_ready` is forced to 0 while `i_loop`=1 and `o_busy`=1.
- Not defined: there is no `i_loop` port, and behaviour is identical to `i_loop`=0.

## Structure
- Package `dac_seq_pkg` holds:
  - the state enum (IDLE, RUN, STALL);
  - default constants for `DW`, `DEPTH` and `DIVW`.
- Sub-module `dac_seq_fifo` implements the synchronous FIFO with count, push/pop and simultaneous push/pop.
- The top level holds the FSM, the divider, and the `o_data`/flag registers.

## Test plan
- Basic playback: push 0x1111, 0x2222, 0x3333; `i_div`=3; `i_start` in cycle 0.
  - `o_tick` fires in cycles 4, 8 and 12; `o_data` reads 0x1111, 0x2222, 0x3333 from cycles 5, 9 and 13.
  - The tick in cycle 16 sets `o_underrun`, the state goes to STALL, and `o_data` stays 0x3333.
- Back-pressure: push 9 words with no playback. `o_level`=8, `o_wr_ready`=0, and the 9th word is dropped; pop order is the first 8 words.
- STALL recovery: while in STALL, push 0xABCD with `i_div`=1.
  - RUN is entered on the next cycle; a tick occurs 2 cycles later and `o_data`=0xABCD.
  - `o_underrun` stays 1 until `i_clr_err`.
- Start/stop priority: `i_start`+`i_stop` together in IDLE leave the state IDLE. `i_stop` during RUN keeps the FIFO, and a restart continues from the next word.
- Async reset: assert `i_resetn`=0 mid-period. All outputs go to their reset values without a clock edge, and `o_level`=0.
- Loop mode (with `DAC_SEQ_LOOP_EN`): load 0xA, 0xB, `i_loop`=1, `i_div`=0.
  - `o_data` sequence is A, B, A, B…; `o_level` stays 2; `o_wr_ready`=0.
